// File: rtl/audio_pwm_pkg.sv
// Shared types and constants for the multi-channel PWM audio output stage.
package audio_pwm_pkg;

  typedef logic [2:0] vol_t;

  localparam vol_t VolFull = 3'd7;

  // Galois LFSR, taps 16,14,13,11, right-shifting form
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic int unsigned midscale(int unsigned pwm_w);
    return 32'd1 << (pwm_w - 1);
  endfunction

endpackage

// File: rtl/pwm_level_conv.sv
// Per-channel sample to PWM level: volume shift, dither add with positive saturation,
// offset-binary truncation to the top PWM_W bits, and mute to midscale.
module pwm_level_conv
  import audio_pwm_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned PWM_W = 8
) (
  input  logic [IN_W-1:0]  sample_i,
  input  vol_t             vol_i,
  input  logic             mute_i,
  input  logic [IN_W-1:0]  dither_i,
  output logic [PWM_W-1:0] level_o
);

  localparam logic [PWM_W-1:0] Mid    = PWM_W'(midscale(PWM_W));
  localparam logic [IN_W-1:0]  PosMax = {1'b0, {(IN_W-1){1'b1}}};

  logic signed [IN_W-1:0] shifted;
  logic        [IN_W:0]   sum;
  logic        [IN_W-1:0] s;
  logic                   unused_lsbs;

  always_comb begin
    shifted = $signed(sample_i) >>> (VolFull - vol_i);
    sum     = {shifted[IN_W-1], shifted} + {1'b0, dither_i};
    // dither is non-negative, so the only possible overflow is past the positive limit
    s       = (sum[IN_W] != sum[IN_W-1]) ? PosMax : sum[IN_W-1:0];
    level_o = mute_i ? Mid : {~s[IN_W-1], s[IN_W-2 -: PWM_W-1]};
  end

  assign unused_lsbs = ^s[IN_W-PWM_W-1:0];

endmodule

// File: rtl/audio_pwm_out.sv
// Multi-channel PWM audio output with one-deep pending buffer and period-aligned updates.
// Optional dither: define AUDIO_PWM_DITHER_EN to add a per-period LFSR value before truncation.
module audio_pwm_out
  import audio_pwm_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [CHANNELS*IN_W-1:0] sample_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  vol_t                     vol_in,
  input  logic                     mute_in,
  output logic [CHANNELS-1:0]      pwm_out,
  output logic                     period_start_out,
  output logic                     underrun_out
);

  logic [PWM_W-1:0]         count_q;
  logic                     boundary;
  logic                     xfer;
  logic                     pending_full_q;
  logic [CHANNELS*IN_W-1:0] pending_q;
  logic [CHANNELS*IN_W-1:0] active_q;
  vol_t                     vol_q;
  logic                     mute_q;
  logic [CHANNELS-1:0]      pwm_q;
  logic [CHANNELS-1:0]      pwm_d;
  logic                     period_start_q;
  logic                     underrun_q;
  logic [IN_W-1:0]          dither;
  logic [PWM_W-1:0]         level [CHANNELS];

  assign boundary         = (count_q == {PWM_W{1'b1}});
  assign ready_out        = ~pending_full_q;
  assign xfer             = valid_in & ~pending_full_q;
  assign pwm_out          = pwm_q;
  assign period_start_out = period_start_q;
  assign underrun_out     = underrun_q;

  // Active sample resets to zero, which converts to midscale at any volume or dither value.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q        <= '0;
      pending_full_q <= 1'b0;
      pending_q      <= '0;
      active_q       <= '0;
      vol_q          <= VolFull;
      mute_q         <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      count_q        <= count_q + PWM_W'(1);
      period_start_q <= boundary;
      underrun_q     <= boundary & ~pending_full_q;
      pwm_q          <= pwm_d;
      if (boundary) begin
        vol_q  <= vol_in;
        mute_q <= mute_in;
      end
      // xfer is impossible while full, so a boundary never races a new write
      if (boundary && pending_full_q) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end else if (xfer) begin
        pending_q      <= sample_in;
        pending_full_q <= 1'b1;
      end
    end
  end

`ifdef AUDIO_PWM_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lfsr_q <= LfsrSeed;
    end else if (boundary) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    end
  end

  always_comb begin
    dither = '0;
    for (int i = 0; i < int'(IN_W - PWM_W) && i < 16; i++) begin
      dither[i] = lfsr_q[i];
    end
  end
`else
  assign dither = '0;
`endif

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
    pwm_level_conv #(
      .IN_W  (IN_W),
      .PWM_W (PWM_W)
    ) u_conv (
      .sample_i (active_q[c*IN_W +: IN_W]),
      .vol_i    (vol_q),
      .mute_i   (mute_q),
      .dither_i (dither),
      .level_o  (level[c])
    );
  end

  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      pwm_d[c] = (count_q < level[c]);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Randomized period-level bench for audio_pwm_out against an arithmetic reference model.
module tb_audio_pwm_out;

  localparam int unsigned IN_W     = 16;
  localparam int unsigned PWM_W    = 8;
  localparam int unsigned CHANNELS = 2;
  localparam int          Period   = 256;

  logic                     clk_in   = 1'b0;
  logic                     rst_n_in = 1'b0;
  logic [CHANNELS*IN_W-1:0] sample_in = '0;
  logic                     valid_in = 1'b0;
  logic                     ready_out;
  logic [2:0]               vol_in   = 3'd7;
  logic                     mute_in  = 1'b0;
  logic [CHANNELS-1:0]      pwm_out;
  logic                     period_start_out;
  logic                     underrun_out;

  always #5 clk_in = ~clk_in;

  audio_pwm_out #(
    .IN_W     (IN_W),
    .PWM_W    (PWM_W),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .sample_in        (sample_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .vol_in           (vol_in),
    .mute_in          (mute_in),
    .pwm_out          (pwm_out),
    .period_start_out (period_start_out),
    .underrun_out     (underrun_out)
  );

  typedef struct {
    int          offer_at;
    bit          two;
    logic [31:0] s0;
    logic [31:0] s1;
    int          chg_at;
    logic [2:0]  vol;
    bit          mute;
    int          rst_at;
  } plan_t;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          count;
  bit          pend;
  logic [31:0] pend_s;
  logic [31:0] act_s;
  int          vol_l;
  bit          mute_l;
  bit          und_exp;
  bit          fresh;
  int          exp_lvl [CHANNELS];
  int          highs   [CHANNELS];
  int          last_high0;
`ifdef AUDIO_PWM_DITHER_EN
  int          lfsr;
`endif

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // offset-binary level from the spec's arithmetic: scale, dither, clamp, take top bits
  function automatic int level_of(logic [15:0] smp, int vol, bit mute, int d);
    int s;
    if (mute) return 128;
    s = int'($signed(smp)) >>> (7 - vol);
    s = s + d;
    if (s > 32767) s = 32767;
    return (s + 32768) / 256;
  endfunction

  task automatic update_levels();
    int d;
    d = 0;
`ifdef AUDIO_PWM_DITHER_EN
    d = lfsr & 255;
`endif
    for (int c = 0; c < int'(CHANNELS); c++)
      exp_lvl[c] = level_of(act_s[c*16 +: 16], vol_l, mute_l, d);
  endtask

  task automatic model_reset();
    count   = 0;
    pend    = 0;
    pend_s  = '0;
    act_s   = '0;
    vol_l   = 7;
    mute_l  = 0;
    und_exp = 0;
    fresh   = 1;
`ifdef AUDIO_PWM_DITHER_EN
    lfsr = 'hACE1;
`endif
    for (int c = 0; c < int'(CHANNELS); c++) highs[c] = 0;
    update_levels();
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("rst_pwm_immediate", int'(pwm_out), 0);
    check_eq("rst_ready", int'(ready_out), 1);
    check_eq("rst_period_start", int'(period_start_out), 0);
    check_eq("rst_underrun", int'(underrun_out), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic run_period(input plan_t p);
    bit xfer;
    do begin
      if (count == p.chg_at) begin
        vol_in  = p.vol;
        mute_in = p.mute;
      end
      valid_in  = (count == p.offer_at) || (p.two && count == p.offer_at + 1);
      sample_in = (count == p.offer_at) ? p.s0 : p.s1;
      check_eq("ready", int'(ready_out), int'(!pend));
      check_eq("period_start", int'(period_start_out), int'(count == 0 && !fresh));
      check_eq("underrun", int'(underrun_out), int'(count == 0 && und_exp));
      if (count != 0)
        for (int c = 0; c < int'(CHANNELS); c++) highs[c] += int'(pwm_out[c]);
      if (count == p.rst_at) begin
        do_reset();
        return;
      end
      xfer = valid_in && !pend;
      if (count == Period - 1) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          check_eq($sformatf("duty_ch%0d", c), highs[c], exp_lvl[c]);
          highs[c] = 0;
        end
        last_high0 = exp_lvl[0];
        if (pend) begin
          act_s   = pend_s;
          pend    = 0;
          und_exp = 0;
        end else begin
          und_exp = 1;
        end
        if (xfer) begin
          pend   = 1;
          pend_s = sample_in;
        end
        vol_l  = int'(vol_in);
        mute_l = mute_in;
`ifdef AUDIO_PWM_DITHER_EN
        lfsr = (lfsr >> 1) ^ (((lfsr & 1) != 0) ? 'hB400 : 0);
`endif
        update_levels();
        fresh = 0;
      end else if (xfer) begin
        pend   = 1;
        pend_s = sample_in;
      end
      @(posedge clk_in); #1;
      count = (count + 1) % Period;
    end while (count != 0);
  endtask

  function automatic plan_t mk(int offer_at, bit two, logic [31:0] s0, logic [31:0] s1,
                               int chg_at, logic [2:0] vol, bit mute, int rst_at);
    plan_t p;
    p.offer_at = offer_at;
    p.two      = two;
    p.s0       = s0;
    p.s1       = s1;
    p.chg_at   = chg_at;
    p.vol      = vol;
    p.mute     = mute;
    p.rst_at   = rst_at;
    return p;
  endfunction

  initial begin
    plan_t p;
`ifdef AUDIO_PWM_DITHER_EN
    int dsum;
`endif
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("reset_pwm", int'(pwm_out), 0);
    check_eq("reset_ready", int'(ready_out), 1);
    check_eq("reset_period_start", int'(period_start_out), 0);
    check_eq("reset_underrun", int'(underrun_out), 0);
    rst_n_in = 1'b1;
    model_reset();

    // idle: midscale with underrun every period
    run_period(mk(-1, 0, 32'h0, 32'h0, -1, 3'd7, 0, -1));
    run_period(mk(-1, 0, 32'h0, 32'h0, -1, 3'd7, 0, -1));
    // full scale: ch0 max positive, ch1 max negative
    run_period(mk(10, 0, {16'h8000, 16'h7FFF}, 32'h0, 0, 3'd7, 0, -1));
    // vol 5 on 16'h4000 -> 144
    run_period(mk(20, 0, {16'h4000, 16'h4000}, 32'h0, 5, 3'd5, 0, -1));
    // backpressure: second valid cycle refused
    run_period(mk(100, 1, {16'hC000, 16'h2000}, {16'h1234, 16'h5678}, -1, 3'd5, 0, -1));
    // mute at count 40 takes effect only at the boundary
    run_period(mk(-1, 0, 32'h0, 32'h0, 40, 3'd5, 1, -1));
    // unmute; transfer lands on the boundary cycle itself
    run_period(mk(255, 0, {16'h7000, 16'h9000}, 32'h0, 0, 3'd7, 0, -1));
    run_period(mk(-1, 0, 32'h0, 32'h0, -1, 3'd7, 0, -1));
    // reset at count 100 with a sample pending
    run_period(mk(50, 0, {16'h3000, 16'hD000}, 32'h0, -1, 3'd7, 0, 100));
    run_period(mk(-1, 0, 32'h0, 32'h0, -1, 3'd7, 0, -1));
    run_period(mk(-1, 0, 32'h0, 32'h0, -1, 3'd7, 0, -1));

    for (int i = 0; i < 24; i++) begin
      p = mk(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 255)),
             bit'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 5) == 0), -1);
      run_period(p);
    end

`ifdef AUDIO_PWM_DITHER_EN
    dsum = 0;
    run_period(mk(0, 0, {16'h0080, 16'h0080}, 32'h0, 0, 3'd7, 0, -1));
    run_period(mk(0, 0, {16'h0080, 16'h0080}, 32'h0, 0, 3'd7, 0, -1));
    for (int i = 0; i < 8; i++) begin
      run_period(mk(0, 0, {16'h0080, 16'h0080}, 32'h0, 0, 3'd7, 0, -1));
      dsum += last_high0;
    end
    check_eq("dither_mean_above_mid", int'(dsum > 128 * 8), 1);
`endif

    valid_in = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
